// File: rtl/iir_tdf2_mc.sv
// Multichannel transposed direct-form-II IIR filter; one tap per cycle on a shared multiplier pair.
// Optional macro IIR_TDF2_SAT_EN selects saturating arithmetic; without it every operation wraps.
module iir_tdf2_mc #(
    parameter int  DW    = 16,
    parameter int  ORDER = 2,
    parameter int  NCH   = 1,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           coef_we,
    input  logic [DW-1:0]  coef_a,
    input  logic [DW-1:0]  coef_b,
    output logic           coef_ready,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  in_data,
    output logic           out_valid,
    output logic [CHW-1:0] out_ch,
    output logic [DW-1:0]  out_data,
    output logic           busy
);
    localparam int AW = 2 * DW;
    localparam int KW = $clog2(ORDER + 1);
    localparam logic [KW-1:0] K_LAST = KW'(ORDER);
    localparam logic signed [AW-1:0] HALF = {{(AW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
`ifdef IIR_TDF2_SAT_EN
    localparam logic signed [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
`endif

    function automatic logic signed [AW-1:0] f_lmult(input logic signed [DW-1:0] p,
                                                      input logic signed [DW-1:0] q);
        logic signed [AW-1:0] prod;
        prod = AW'(p) * AW'(q);
`ifdef IIR_TDF2_SAT_EN
        // Only min*min overflows the doubling; it shows up as differing top two bits.
        if (prod[AW-1] != prod[AW-2]) f_lmult = prod[AW-1] ? SMIN : SMAX;
        else                          f_lmult = prod << 1;
`else
        f_lmult = prod << 1;
`endif
    endfunction

    function automatic logic signed [AW-1:0] f_ladd(input logic signed [AW-1:0] p,
                                                     input logic signed [AW-1:0] q);
`ifdef IIR_TDF2_SAT_EN
        logic signed [AW:0] sum;
        sum = {p[AW-1], p} + {q[AW-1], q};
        if (sum[AW] != sum[AW-1]) f_ladd = sum[AW] ? SMIN : SMAX;
        else                      f_ladd = sum[AW-1:0];
`else
        f_ladd = p + q;
`endif
    endfunction

    function automatic logic signed [DW-1:0] f_round(input logic signed [AW-1:0] v);
        f_round = DW'(f_ladd(v, HALF) >>> DW);
    endfunction

    function automatic logic signed [DW-1:0] f_neg(input logic signed [DW-1:0] y);
`ifdef IIR_TDF2_SAT_EN
        f_neg = (y == DMIN) ? DMAX : -y;
`else
        f_neg = -y;
`endif
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_OUT, S_UPD} state_t;

    state_t               r_state, w_state_next;
    logic signed [DW-1:0] r_b [0:ORDER];
    logic signed [DW-1:0] r_a [1:ORDER];
    logic signed [DW-1:0] r_x, r_yn;
    logic [CHW-1:0]       r_ch;
    logic [KW-1:0]        r_k;
    logic                 r_out_valid;
    logic [CHW-1:0]       r_out_ch;
    logic [DW-1:0]        r_out_data;

    logic                 w_idle, w_coef_fire, w_accept, w_ch_ok, w_upd;
    logic [KW-1:0]        w_k_rd;
    int                   w_rd_idx, w_wr_idx;
    logic signed [DW-1:0] w_b, w_a, w_y;
    logic signed [AW-1:0] w_s_rd, w_mb, w_ma, w_s_new;
    logic signed [AW-1:0] w_s_all [0:NCH*ORDER-1];

    assign w_idle      = (r_state == S_IDLE);
    assign w_coef_fire = w_idle && coef_we;
    assign w_accept    = in_valid && w_idle && !coef_we;
    assign w_ch_ok     = (int'(in_ch) < NCH);
    assign w_upd       = (r_state == S_UPD);

    assign coef_ready = w_idle;
    assign in_ready   = w_idle && !coef_we;
    assign busy       = !w_idle;
    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_data   = r_out_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= ORDER; k++) r_b[k] <= '0;
            for (int k = 1; k <= ORDER; k++) r_a[k] <= '0;
        end else if (w_coef_fire) begin
            for (int k = 0; k < ORDER; k++) r_b[k] <= r_b[k+1];
            for (int k = 1; k < ORDER; k++) r_a[k] <= r_a[k+1];
            r_b[ORDER] <= coef_b;
            r_a[ORDER] <= coef_a;
        end
    end

    // State words, flattened as index ch*ORDER + k; a reload wipes every channel.
    for (genvar gi = 0; gi < NCH*ORDER; gi++) begin : g_state
        logic signed [AW-1:0] r_word;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)                           r_word <= '0;
            else if (w_coef_fire)                r_word <= '0;
            else if (w_upd && w_wr_idx == gi)    r_word <= w_s_new;
        end
        assign w_s_all[gi] = r_word;
    end

    // OUT evaluates tap 0; UPD evaluates tap k, where tap ORDER has no incoming state.
    always_comb begin
        w_k_rd   = (r_state == S_OUT) ? '0 : r_k;
        w_rd_idx = int'(r_ch) * ORDER + int'(w_k_rd);
        w_wr_idx = int'(r_ch) * ORDER + int'(r_k) - 1;
        w_b = '0;
        for (int k = 0; k <= ORDER; k++) if (k == int'(w_k_rd)) w_b = r_b[k];
        w_a = '0;
        for (int k = 1; k <= ORDER; k++) if (k == int'(r_k)) w_a = r_a[k];
        w_s_rd = '0;
        if (int'(w_k_rd) < ORDER)
            for (int i = 0; i < NCH*ORDER; i++) if (i == w_rd_idx) w_s_rd = w_s_all[i];
        w_mb    = f_lmult(w_b, r_x);
        w_ma    = f_lmult(r_yn, w_a);
        w_y     = f_round(f_ladd(w_mb, w_s_rd));
        w_s_new = f_ladd(f_ladd(w_mb, w_ma), w_s_rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_ch_ok) w_state_next = S_OUT;
            S_OUT:   w_state_next = S_UPD;
            S_UPD:   if (r_k == K_LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_ch        <= '0;
            r_yn        <= '0;
            r_k         <= KW'(1);
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_ch_ok) begin
                        r_x  <= in_data;
                        r_ch <= in_ch;
                    end
                end
                S_OUT: begin
                    r_out_data  <= w_y;
                    r_out_ch    <= r_ch;
                    r_out_valid <= 1'b1;
                    r_yn        <= f_neg(w_y);
                    r_k         <= KW'(1);
                end
                S_UPD: begin
                    r_k <= (r_k == K_LAST) ? KW'(1) : r_k + KW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_tdf2_mc.sv
// Scoreboard bench for iir_tdf2_mc: directed cases from known results plus random traffic
// checked against an arithmetic reference model of the recursion.
module tb_iir_tdf2_mc;
    localparam int DW = 16, ORDER = 2, NCH = 3, CHW = 2;
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic           clk = 1'b0, reset = 1'b1, coef_we = 1'b0, in_valid = 1'b0;
    logic [DW-1:0]  coef_a = '0, coef_b = '0, in_data = '0;
    logic [CHW-1:0] in_ch = '0;
    logic           coef_ready, in_ready, out_valid, busy;
    logic [CHW-1:0] out_ch;
    logic [DW-1:0]  out_data;

    int n_checks = 0, n_fail = 0, cyc = 0;

    iir_tdf2_mc #(.DW(DW), .ORDER(ORDER), .NCH(NCH)) dut (
        .clk(clk), .reset(reset), .coef_we(coef_we), .coef_a(coef_a), .coef_b(coef_b),
        .coef_ready(coef_ready), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_data(in_data), .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
        .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    // Reference model: the recursion evaluated with 64-bit integers.
    longint m_b [0:ORDER];
    longint m_a [0:ORDER];
    longint m_s [0:NCH-1][0:ORDER-1];

    function automatic longint fix(input longint v);
`ifdef IIR_TDF2_SAT_EN
        if (v > LMAX) return LMAX;
        if (v < LMIN) return LMIN;
        return v;
`else
        longint w;
        w = v & 64'h0000_0000_FFFF_FFFF;
        if (w > LMAX) w = w - 64'sd4294967296;
        return w;
`endif
    endfunction

    function automatic longint m_lmult(input longint p, input longint q);
        return fix(p * q * 2);
    endfunction
    function automatic longint m_ladd(input longint p, input longint q);
        return fix(p + q);
    endfunction
    function automatic longint m_round(input longint v);
        return fix(v + 32768) >>> 16;
    endfunction
    function automatic longint m_neg(input longint y);
        if (y == -32768) begin
`ifdef IIR_TDF2_SAT_EN
            return 32767;
`else
            return -32768;
`endif
        end
        return -y;
    endfunction

    function automatic longint m_step(input int ch, input longint x);
        longint y, yn;
        y  = m_round(m_ladd(m_lmult(m_b[0], x), m_s[ch][0]));
        yn = m_neg(y);
        for (int k = 1; k < ORDER; k++)
            m_s[ch][k-1] = m_ladd(m_ladd(m_lmult(m_b[k], x), m_lmult(yn, m_a[k])), m_s[ch][k]);
        m_s[ch][ORDER-1] = m_ladd(m_lmult(m_b[ORDER], x), m_lmult(yn, m_a[ORDER]));
        return y;
    endfunction

    function automatic void m_clear_state();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < ORDER; k++) m_s[c][k] = 0;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k <= ORDER; k++) begin
            m_b[k] = 0;
            m_a[k] = 0;
        end
        m_clear_state();
    endfunction

    function automatic void m_shift(input logic [DW-1:0] ca, input logic [DW-1:0] cb);
        for (int k = 0; k < ORDER; k++) begin
            m_b[k] = m_b[k+1];
            m_a[k] = m_a[k+1];
        end
        m_b[ORDER] = longint'($signed(cb));
        m_a[ORDER] = longint'($signed(ca));
        m_clear_state();
    endfunction

    typedef struct {
        int            ch;
        logic [DW-1:0] y;
        int            cyc;
    } exp_t;
    exp_t q[$];
    exp_t e_mon;
    logic [DW-1:0] hold;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per out_valid pulse and checks data, tag and timing.
    always @(negedge clk) begin
        if (reset) begin
            hold = '0;
        end else if (out_valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: ch=%0d data=%h at cycle %0d with nothing expected",
                         out_ch, out_data, cyc);
            end else begin
                e_mon = q.pop_front();
                if (int'(out_ch) != e_mon.ch || out_data !== e_mon.y || cyc != e_mon.cyc) begin
                    n_fail++;
                    $display("FAIL out_sample: got ch=%0d data=%h cycle=%0d, expected ch=%0d data=%h cycle=%0d",
                             out_ch, out_data, cyc, e_mon.ch, e_mon.y, e_mon.cyc);
                end else begin
                    $display("out ch=%0d data=%h cycle=%0d", out_ch, out_data, cyc);
                end
            end
            hold = out_data;
        end else begin
            n_checks++;
            if (out_data !== hold) begin
                n_fail++;
                $display("FAIL out_hold: got %h, expected held %h", out_data, hold);
            end
        end
    end

    task automatic send(input int ch, input logic [DW-1:0] x, input bit use_exp,
                        input logic [DW-1:0] exp_y);
        int waited;
        longint y;
        exp_t e;
        @(negedge clk); #1;
        in_valid = 1'b1;
        in_ch    = CHW'(ch);
        in_data  = x;
        #1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk); #2;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
            in_valid = 1'b0;
            return;
        end
        if (ch < NCH) begin
            y     = m_step(ch, longint'($signed(x)));
            e.ch  = ch;
            e.y   = use_exp ? exp_y : DW'(y);
            e.cyc = cyc + 2;
            q.push_back(e);
        end
        $display("in  ch=%0d x=%h cycle=%0d", ch, x, cyc);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] ca, input logic [DW-1:0] cb);
        int waited;
        @(negedge clk); #1;
        coef_we = 1'b1;
        coef_a  = ca;
        coef_b  = cb;
        #1;
        waited = 0;
        while (!coef_ready && waited < 100) begin
            @(negedge clk); #2;
            waited++;
        end
        if (!coef_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL coef_timeout: coef_ready stayed 0, expected 1 within 100 cycles");
            coef_we = 1'b0;
            return;
        end
        m_shift(ca, cb);
        $display("coef a=%h b=%h", ca, cb);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic load3(input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2,
                         input logic [DW-1:0] a1, input logic [DW-1:0] a2);
        load(16'h0000, b0);
        load(a1, b1);
        load(a2, b2);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy || q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, expected 0 and 0", busy, q.size());
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_ch"}, out_ch, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_coef_ready"}, coef_ready, 1);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        q.delete();
        m_reset();
        $display("reset %s", tag);
        @(negedge clk); #1;
        check_reset_vals(tag);
        @(negedge clk); #2;
        reset = 1'b0;
    endtask

    initial begin
        m_reset();
        @(negedge clk); #1;
        check_reset_vals("rst");
        @(negedge clk); #2;
        reset = 1'b0;

        // Passthrough with latency and busy-window checks.
        load3(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        send(0, 16'h4000, 1'b1, 16'h4000);
        for (int i = 0; i <= ORDER; i++) begin
            @(negedge clk); #1;
            chk("in_ready_low_after_accept", in_ready, 0);
            chk("busy_after_accept", busy, 1);
        end
        @(negedge clk); #1;
        chk("in_ready_back_high", in_ready, 1);
        wait_idle();

        // Recursion: impulse decays by half each sample.
        load3(16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
        send(0, 16'h4000, 1'b1, 16'h2000);
        send(0, 16'h0000, 1'b1, 16'h1000);
        send(0, 16'h0000, 1'b1, 16'h0800);
        send(0, 16'h0000, 1'b1, 16'h0400);
        wait_idle();

        // Saturation of the accumulated state.
        load3(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
        send(0, 16'h7FFF, 1'b1, 16'h7FFE);
`ifdef IIR_TDF2_SAT_EN
        send(0, 16'h7FFF, 1'b1, 16'h7FFF);
`else
        send(0, 16'h7FFF, 1'b1, 16'hFFFC);
`endif
        // Most-negative times most-negative product.
        load3(16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`ifdef IIR_TDF2_SAT_EN
        send(0, 16'h8000, 1'b1, 16'h7FFF);
`else
        send(0, 16'h8000, 1'b1, 16'h8000);
`endif
        wait_idle();

        // Channel isolation with interleaved traffic.
        load3(16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
        send(0, 16'h4000, 1'b1, 16'h2000);
        send(1, 16'h0000, 1'b1, 16'h0000);
        send(0, 16'h0000, 1'b1, 16'h1000);
        send(1, 16'h0000, 1'b1, 16'h0000);
        send(0, 16'h0000, 1'b1, 16'h0800);
        send(1, 16'h0000, 1'b1, 16'h0000);
        wait_idle();

        // Reload mid-decay clears state.
        load3(16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
        send(0, 16'h0000, 1'b1, 16'h0000);
        wait_idle();

        // Out-of-range channel is accepted and dropped.
        send(3, 16'h1234, 1'b0, 16'h0000);
        @(negedge clk); #1;
        chk("drop_stays_idle", busy, 0);
        send(0, 16'h4000, 1'b1, 16'h2000);
        wait_idle();

        // Simultaneous coefficient write and sample offer.
        @(negedge clk); #1;
        coef_we = 1'b1; coef_a = 16'h0000; coef_b = 16'h0000;
        in_valid = 1'b1; in_ch = 2'd0; in_data = 16'h7FFF;
        #1;
        chk("simul_in_ready", in_ready, 0);
        chk("simul_coef_ready", coef_ready, 1);
        m_shift(16'h0000, 16'h0000);
        $display("coef a=0000 b=0000 with sample offered");
        @(posedge clk); #1;
        coef_we = 1'b0; in_valid = 1'b0;
        @(negedge clk); #1;
        chk("simul_not_busy", busy, 0);
        repeat (4) @(negedge clk);

        // Reset while the sample sits in OUT: aborted, no pulse.
        load3(16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
        send(0, 16'h4000, 1'b0, 16'h0000);
        #1;
        do_reset("rst_out");
        repeat (4) @(negedge clk);

        // Reset during UPD, then filter from a clean state.
        load3(16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
        send(0, 16'h4000, 1'b1, 16'h2000);
        @(posedge clk);
        @(posedge clk); #2;
        do_reset("rst_upd");
        load3(16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000);
        send(0, 16'h0000, 1'b1, 16'h0000);
        send(0, 16'h4000, 1'b1, 16'h2000);
        send(0, 16'h0000, 1'b1, 16'h1000);
        wait_idle();

        // Random traffic against the model.
        for (int r = 0; r <= ORDER; r++) load(16'($urandom), 16'($urandom));
        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 19) == 0) load(16'($urandom), 16'($urandom));
            send(int'($urandom_range(0, 3)), 16'($urandom), 1'b0, 16'h0000);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_idle();
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
